// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared types, constants and width helpers for the SIFT octave pipeline
// Purpose: FSM state encoding for the downsampler, decimation mode constants and
//          counter-width helpers used by octave_downsample and ds_raster_cnt.
// Ports:   none (package).
package sift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ds_state_e;

  localparam int MODE_PICK = 0;
  localparam int MODE_BOX  = 1;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // log2 of a power-of-two factor; never less than one bit.
  function automatic int log2_w(input int f);
    return (f <= 2) ? 1 : $clog2(f);
  endfunction

endpackage

// File: rtl/ds_raster_cnt.sv
// rtl/ds_raster_cnt.sv - raster x/y position counters with wrap flags and decimation phase
// Purpose: tracks the coordinate of the pixel on the input bus. The registers hold the
//          position of the next expected pixel; a restart beat is pixel (0,0) itself.
// Ports:   iclk, irst    clock and synchronous active-high reset
//          restart       current beat is a start-of-frame beat
//          adv           current beat is accepted; step to the next position
//          cur_x, cur_y  coordinate of the current beat
//          x_last/y_last current beat is on the last column / last line
//          x_ph, y_ph    cur_x % FACTOR, cur_y % FACTOR
module ds_raster_cnt
  import sift_pkg::*;
#(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int FACTOR = 2,
  parameter int XW     = cnt_w(IMG_W),
  parameter int YW     = cnt_w(IMG_H),
  parameter int PW     = log2_w(FACTOR)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          restart,
  input  logic          adv,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          x_last,
  output logic          y_last,
  output logic [PW-1:0] x_ph,
  output logic [PW-1:0] y_ph
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  assign cur_x  = restart ? '0 : x_q;
  assign cur_y  = restart ? '0 : y_q;
  assign x_last = (cur_x == XW'(IMG_W - 1));
  assign y_last = (cur_y == YW'(IMG_H - 1));
  // FACTOR is a power of two, so the phase is just the low bits of the coordinate.
  assign x_ph   = PW'(cur_x);
  assign y_ph   = PW'(cur_y);

  always_ff @(posedge iclk) begin
    if (irst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv) begin
      x_q <= x_last ? '0 : cur_x + XW'(1);
      if (x_last) y_q <= y_last ? '0 : cur_y + YW'(1);
      else        y_q <= cur_y;
    end
  end

endmodule

// File: rtl/octave_downsample.sv
// rtl/octave_downsample.sv - 2-D decimator producing the next SIFT octave from a raster stream
// Purpose: keeps one pixel per FACTOR x FACTOR block (MODE_PICK) or the rounded mean of
//          FACTOR horizontal pixels on kept rows (MODE_BOX); all outputs registered one
//          cycle after the deciding input beat.
// Ports:   iclk, irst   clock and synchronous active-high reset
//          iSof         start of frame, qualified by iDval
//          iDval, iData input pixel strobe and value
//          oData_en     single-cycle output pixel strobe; oData holds between strobes
//          oData        output pixel
//          oMAC_en      oData_en restricted to input columns below AUX_LEN
//          oLine_end    last output pixel of a kept row
//          oFrame_end   last output pixel of the frame
module octave_downsample
  import sift_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int FACTOR  = 2,
  parameter int PHASE_X = 0,
  parameter int PHASE_Y = 0,
  parameter int MODE    = 0,
  parameter int AUX_LEN = 259
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iSof,
  input  logic              iDval,
  input  logic [DATA_W-1:0] iData,
  output logic              oData_en,
  output logic [DATA_W-1:0] oData,
  output logic              oMAC_en,
  output logic              oLine_end,
  output logic              oFrame_end
);

  localparam int XW = cnt_w(IMG_W);
  localparam int YW = cnt_w(IMG_H);
  localparam int PW = log2_w(FACTOR);
  localparam int SW = DATA_W + PW;
  // Column of the last emitted pixel in a line and the last kept row of the frame.
  localparam int LAST_X = (MODE == MODE_BOX) ? IMG_W - 1 : IMG_W - FACTOR + PHASE_X;
  localparam int LAST_Y = PHASE_Y + FACTOR * ((IMG_H - 1 - PHASE_Y) / FACTOR);
  localparam int unsigned AUX_U = AUX_LEN;

  if ((IMG_W % FACTOR) != 0 || FACTOR < 2 || FACTOR > 8 ||
      (FACTOR & (FACTOR - 1)) != 0 || PHASE_X >= FACTOR || PHASE_Y >= FACTOR) begin : g_param_err
    $error("octave_downsample: illegal FACTOR/PHASE/IMG_W combination");
  end

  ds_state_e     state_q, state_d;
  logic [SW-1:0] acc_q;

  logic          accept, restart;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          x_last, y_last;
  logic [PW-1:0] x_ph, y_ph;

  logic              emit, line_hit, frame_hit, mac_ok;
  logic [SW-1:0]     sum_now, rounded;
  logic [DATA_W-1:0] out_val;

  // Outside RUN only a start-of-frame beat is taken; in RUN it resynchronises.
  assign restart = iDval & iSof;
  assign accept  = iDval & (iSof | (state_q == ST_RUN));

  ds_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .FACTOR(FACTOR),
    .XW    (XW),
    .YW    (YW),
    .PW    (PW)
  ) u_cnt (
    .iclk   (iclk),
    .irst   (irst),
    .restart(restart),
    .adv    (accept),
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .x_last (x_last),
    .y_last (y_last),
    .x_ph   (x_ph),
    .y_ph   (y_ph)
  );

  always_ff @(posedge iclk) begin
    if (irst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    line_hit  = 1'b0;
    frame_hit = 1'b0;
    mac_ok    = 1'b0;
    // Group start discards the old sum, so no explicit clear is needed on resync.
    sum_now   = ((x_ph == '0) ? '0 : acc_q) + SW'(iData);
    rounded   = sum_now + SW'(FACTOR / 2);
    out_val   = iData;

    if (accept) begin
      state_d = (x_last && y_last) ? ST_DONE : ST_RUN;
      if (MODE == MODE_BOX) begin
        emit    = (y_ph == PW'(PHASE_Y)) && (x_ph == PW'(FACTOR - 1));
        out_val = DATA_W'(rounded >> PW);
      end else begin
        emit    = (y_ph == PW'(PHASE_Y)) && (x_ph == PW'(PHASE_X));
      end
      line_hit  = (cur_x == XW'(LAST_X));
      frame_hit = line_hit && (cur_y == YW'(LAST_Y));
      mac_ok    = (32'(cur_x) < AUX_U);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      acc_q      <= '0;
      oData_en   <= 1'b0;
      oData      <= '0;
      oMAC_en    <= 1'b0;
      oLine_end  <= 1'b0;
      oFrame_end <= 1'b0;
    end else begin
      if (accept) acc_q <= sum_now;
      oData_en   <= emit;
      oMAC_en    <= emit & mac_ok;
      oLine_end  <= emit & line_hit;
      oFrame_end <= emit & frame_hit;
      if (emit) oData <= out_val;
    end
  end

endmodule

// File: tb/tb_octave_downsample.sv
// tb/tb_octave_downsample.sv - scoreboard bench for octave_downsample across four configurations
module tb_octave_downsample;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sof = 1'b0;
  logic       dval = 1'b0;
  logic [7:0] data = 8'd0;

  logic       en   [4];
  logic [7:0] dat  [4];
  logic       mac  [4];
  logic       le   [4];
  logic       fe   [4];

  always #5 clk = ~clk;

  // 0: pick, phase 0, AUX_LEN 5   1: pick, phase 1/1
  // 2: box mean, FACTOR 4         3: 512-wide line, AUX_LEN 259
  octave_downsample #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .FACTOR(2), .PHASE_X(0), .PHASE_Y(0),
                      .MODE(0), .AUX_LEN(5)) u_a (
    .iclk(clk), .irst(rst), .iSof(sof), .iDval(dval), .iData(data),
    .oData_en(en[0]), .oData(dat[0]), .oMAC_en(mac[0]), .oLine_end(le[0]), .oFrame_end(fe[0]));
  octave_downsample #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .FACTOR(2), .PHASE_X(1), .PHASE_Y(1),
                      .MODE(0), .AUX_LEN(259)) u_b (
    .iclk(clk), .irst(rst), .iSof(sof), .iDval(dval), .iData(data),
    .oData_en(en[1]), .oData(dat[1]), .oMAC_en(mac[1]), .oLine_end(le[1]), .oFrame_end(fe[1]));
  octave_downsample #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .FACTOR(4), .PHASE_X(0), .PHASE_Y(0),
                      .MODE(1), .AUX_LEN(259)) u_c (
    .iclk(clk), .irst(rst), .iSof(sof), .iDval(dval), .iData(data),
    .oData_en(en[2]), .oData(dat[2]), .oMAC_en(mac[2]), .oLine_end(le[2]), .oFrame_end(fe[2]));
  octave_downsample #(.DATA_W(8), .IMG_W(512), .IMG_H(2), .FACTOR(2), .PHASE_X(0), .PHASE_Y(0),
                      .MODE(0), .AUX_LEN(259)) u_d (
    .iclk(clk), .irst(rst), .iSof(sof), .iDval(dval), .iData(data),
    .oData_en(en[3]), .oData(dat[3]), .oMAC_en(mac[3]), .oLine_end(le[3]), .oFrame_end(fe[3]));

  typedef struct {
    int data;
    int le;
    int fe;
    int mac;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   sel = 0;
  int   n_pop = 0;
  int   n_en3 = 0;
  int   n_mac3 = 0;

  // reference model state and configuration of the selected instance
  int cw, ch, cf, cpx, cpy, cmode, caux;
  int m_state, mx, my, macc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en[sel]) begin
      check("queue_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_pop++;
        check("data", int'(dat[sel]), e.data);
        check("line_end", int'(le[sel]), e.le);
        check("frame_end", int'(fe[sel]), e.fe);
        check("mac_en", int'(mac[sel]), e.mac);
        check("latency_cycle", cyc, e.cyc);
      end
      if (sel == 3) begin
        n_en3++;
        if (mac[sel]) n_mac3++;
      end
    end else if (le[sel] | fe[sel] | mac[sel]) begin
      check("stray_flags", int'({le[sel], fe[sel], mac[sel]}), 0);
    end
  end

  task automatic setup(input int s, input int w, input int h, input int f, input int px,
                       input int py, input int md, input int aux);
    sel = s; cw = w; ch = h; cf = f; cpx = px; cpy = py; cmode = md; caux = aux;
    n_pop = 0;
  endtask

  task automatic model(input logic s, input int d);
    int xp, yp, lastx, lasty;
    bit emit_m;
    exp_t e;
    if (!(m_state == 1 || s)) return;
    if (s) begin mx = 0; my = 0; end
    xp = mx % cf;
    yp = my % cf;
    macc = ((xp == 0) ? 0 : macc) + d;
    lastx = -1;
    for (int x = 0; x < cw; x++)
      if ((cmode == 0) ? (x % cf == cpx) : (x % cf == cf - 1)) lastx = x;
    lasty = -1;
    for (int y = 0; y < ch; y++)
      if (y % cf == cpy) lasty = y;
    emit_m = (cmode == 0) ? (xp == cpx && yp == cpy) : (yp == cpy && xp == cf - 1);
    if (emit_m) begin
      e.data = (cmode == 0) ? d : (macc + cf / 2) / cf;
      e.le   = (mx == lastx) ? 1 : 0;
      e.fe   = (mx == lastx && my == lasty) ? 1 : 0;
      e.mac  = (mx < caux) ? 1 : 0;
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
    m_state = 1;
    if (mx == cw - 1) begin
      mx = 0;
      if (my == ch - 1) begin my = 0; m_state = 2; end
      else my++;
    end else mx++;
  endtask

  task automatic beat(input logic s, input int d);
    sof = s; dval = 1'b1; data = d[7:0];
    model(s, d);
    @(posedge clk); #1;
    sof = 1'b0; dval = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_state = 0; mx = 0; my = 0; macc = 0;
    check("rst_data_en", int'(en[sel]), 0);
    check("rst_data", int'(dat[sel]), 0);
    check("rst_flags", int'({mac[sel], le[sel], fe[sel]}), 0);
  endtask

  task automatic frame(input int n, input int gaps);
    for (int i = 0; i < n; i++) begin
      beat(i == 0, i % 256);
      if (gaps != 0) idle($urandom_range(0, 3));
    end
  endtask

  task automatic drain(input string tag, input int exp_cnt);
    idle(3);
    check({tag, "_drain"}, int'(q.size()), 0);
    check({tag, "_count"}, n_pop, exp_cnt);
  endtask

  initial begin
    int row3[8];
    row3 = '{1, 2, 3, 4, 255, 255, 255, 254};
    idle(2);

    // ramp frame, keep even/even; trailing beats without iSof land in DONE
    setup(0, 8, 4, 2, 0, 0, 0, 5);
    do_reset();
    frame(32, 0);
    for (int i = 0; i < 4; i++) beat(1'b0, 100 + i);
    drain("pick_ph0", 8);

    setup(1, 8, 4, 2, 1, 1, 0, 259);
    do_reset();
    frame(32, 0);
    drain("pick_ph1", 8);

    // box mean over 4 pixels on row 0 only
    setup(2, 8, 4, 4, 0, 0, 1, 259);
    do_reset();
    for (int i = 0; i < 8; i++) beat(i == 0, row3[i]);
    for (int i = 8; i < 32; i++) beat(1'b0, i);
    drain("box4", 2);

    setup(0, 8, 4, 2, 0, 0, 0, 5);
    do_reset();
    frame(32, 1);
    drain("gaps", 8);

    // resync at y=1, second resync run into row 2, then reset mid-frame
    setup(0, 8, 4, 2, 0, 0, 0, 5);
    do_reset();
    frame(12, 0);
    frame(20, 0);
    do_reset();
    for (int i = 0; i < 10; i++) beat(1'b0, 50 + i);
    frame(32, 0);
    drain("resync_reset", 18);

    setup(3, 512, 2, 2, 0, 0, 0, 259);
    do_reset();
    n_en3 = 0; n_mac3 = 0;
    frame(1024, 0);
    drain("wide", 256);
    check("wide_data_en_pulses", n_en3, 256);
    check("wide_mac_en_pulses", n_mac3, 130);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
